mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access unit of the RISC-V pipeline. It consumes the EX/MEM pipeline register outputs, performs loads and stores over a single-outstanding valid/ack data bus, and returns extracted load data toward MEM/WB. It generates byte enables, load alignment and extension, misalignment detection, and a pipeline stall for multi-cycle memory.

## Interface
Parameters:
- `OP_LOAD`, default 7'b0000011: opcode identifying a load.
- `OP_STORE`, default 7'b0100011: opcode identifying a store.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `memValid`, in, 1: MEM stage holds a live instruction.
- `memInsType`, in, 7: opcode of the MEM-stage instruction.
- `memFunct3`, in, 3: access width and sign.
- `memMEMWrite`, in, 1: store enable from decode.
- `memResult`, in, 32: ALU-computed byte address.
- `memMEMWdata`, in, 32: store data in rs2 format.
- `dbus_req`, out, 1: bus request.
- `dbus_we`, out, 1: bus write.
- `dbus_addr`, out, 32: word address, with bits [1:0] always 0.
- `dbus_wdata`, out, 32: lane-replicated store data.
- `dbus_be`, out, 4: byte enables.
- `dbus_ack`, in, 1: bus completion.
- `dbus_rdata`, in, 32: read word, valid with `dbus_ack` on loads.
- `memStall`, out, 1: freeze IF through MEM.
- `memLoadData`, out, 32: extended load result.
- `memLoadDone`, out, 1: one-cycle pulse when `memLoadData` is fresh.
- `memMisalign`, out, 1: misaligned access detected (combinational flag).

## Operation
Access classification:
- Load: `memValid` and `memInsType == OP_LOAD`. Legal `memFunct3` values are 0 (LB), 1 (LH), 2 (LW), 4 (LBU), 5 (LHU).
- Store: `memValid`, `memInsType == OP_STORE` and `memMEMWrite`. Legal `memFunct3` values are 0 (SB), 1 (SH), 2 (SW).
- Illegal `memFunct3`: no request, no stall, `memMisalign` = 0.

Misalignment:
- A halfword access with `addr[0] = 1`, or a word access with `addr[1:0] != 0`, is misaligned.
- On a misaligned access: `memMisalign` = 1 in that cycle, no bus request, no stall. A misaligned store writes nothing.

State machine (IDLE, REQ, DONE):
- IDLE → REQ: on an aligned legal access. In the same edge, register `dbus_addr = {addr[31:2], 2'b00}`, `dbus_we`, `dbus_be` and `dbus_wdata`.
- REQ: `dbus_req` = 1. All `dbus_*` outputs are held stable until `dbus_ack`.
- REQ → DONE: on `dbus_ack`. A load captures its extracted data into `memLoadData`.
- DONE → IDLE: unconditionally. `memLoadDone` = 1 in DONE, loads only.
- DONE never starts an access. The instruction present in DONE is the one just served.

Byte enables and store data:
- SB: `be = 4'b0001 << addr[1:0]`; `wdata = {4{wdata[7:0]}}`.
- SH: `be = 4'b0011 << {addr[1], 1'b0}`; `wdata = {2{wdata[15:0]}}`.
- SW: `be = 4'b1111`; `wdata` unchanged.
- Loads: `be = 4'b1111`.

Load extraction:
- Byte lane selected by `addr[1:0]`; halfword lane selected by `addr[1]`.
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.

Stall:
- `memStall = (IDLE & aligned legal access) | REQ`. It is deasserted in DONE.

Other rules:
- `dbus_ack` is ignored outside REQ.
- `memLoadData` holds its value until the next load completes.

## Timing
Reset (asynchronous, immediate, including mid-REQ): state IDLE and all of the following are 0:
- `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_wdata`, `dbus_be`.
- `memLoadData`, `memLoadDone`, `memStall`, `memMisalign`.

An abandoned transaction is not resumed after reset.

Cycle sequence with zero-wait memory (`dbus_ack` high in the first REQ cycle):
- Cycle 0: access detected, stall = 1.
- Cycle 1: REQ, ack seen.
- Cycle 2: DONE, stall = 0, `memLoadDone` = 1.
- Total occupancy is 3 cycles. Each extra wait state adds 1 cycle.

Back-to-back accesses: the next instruction's access begins in the cycle after DONE.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants `OP_LOAD` and `OP_STORE`;
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - enum `lsu_state_t` with values {IDLE, REQ, DONE}.
- One combinational sub-module, `lsu_load_align`: inputs `rdata`, `addr[1:0]` and `funct3`; output is the 32-bit extended value.
- Store lane and byte-enable generation stays inline.

## Test plan
- LB from 0x103 with `dbus_rdata` = 0x80FF_1234, zero-wait → `dbus_addr` = 0x100, `memLoadData` = 0xFFFF_FF80, stall high for exactly 2 cycles, `memLoadDone` pulses once.
- SH to 0x202 with data 0x0000_ABCD → `dbus_be` = 4'b1100, `dbus_wdata` = 0xABCD_ABCD, `dbus_we` = 1.
- LW with 3 wait states → `dbus_*` stable across all 4 REQ cycles, stall asserted for 5 cycles.
- LW to 0x102 → `memMisalign` = 1, `dbus_req` never asserted, stall 0.
- `rst` low in the second REQ cycle → `dbus_req` = 0 immediately; after release, state is IDLE and a spurious `dbus_ack` produces no `memLoadDone`.
- LHU from 0x002 then SB to 0x001 back-to-back, `rdata` = 0x8001_0000 → `memLoadData` = 0x0000_8001; the SB request starts in the cycle after DONE with `be` = 4'b0010.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: memory opcodes, load/store funct3
// encodings, the load/store unit state type and the registered data-bus
// command record.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

  // Everything the bus sees besides req; captured once per access.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dbus_cmd_t;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and extension.
// Ports:
//   rdata  - raw 32-bit word from the data bus
//   addr   - low two bits of the byte address (lane select)
//   funct3 - load width/sign encoding
//   data   - lane-extracted, sign/zero-extended load value
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(rdata >> {addr, 3'b000});
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_BU:   data = {24'h0, b};
      F3_HU:   data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Classifies the EX/MEM instruction as a
// load/store, flags misalignment, issues one access at a time on a
// valid/ack bus and stalls the pipeline until the access completes.
// Ports:
//   clk, rst           - clock, async active-low reset
//   memValid..memMEMWdata - EX/MEM pipeline register fields
//   dbus_*             - single-outstanding data bus (req/we/addr/wdata/be out,
//                        ack/rdata in)
//   memStall           - freezes IF..MEM while an access is pending
//   memLoadData        - last completed load value (held)
//   memLoadDone        - one-cycle pulse when memLoadData is fresh
//   memMisalign        - combinational misaligned-access flag
module mem_access_unit #(
  parameter logic [6:0] OP_LOAD  = riscv_pkg::OP_LOAD,
  parameter logic [6:0] OP_STORE = riscv_pkg::OP_STORE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memValid,
  input  logic [6:0]  memInsType,
  input  logic [2:0]  memFunct3,
  input  logic        memMEMWrite,
  input  logic [31:0] memResult,
  input  logic [31:0] memMEMWdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        memStall,
  output logic [31:0] memLoadData,
  output logic        memLoadDone,
  output logic        memMisalign
);

  import riscv_pkg::*;

  lsu_state_t  state;
  dbus_cmd_t   cmd, cmd_nxt;
  logic        is_load, is_store, legal, misal, go;
  logic [1:0]  lo_q;
  logic [2:0]  f3_q;
  logic [31:0] ld_ext;

  // Classification and misalignment.
  always_comb begin
    is_load  = memValid && (memInsType == OP_LOAD);
    is_store = memValid && (memInsType == OP_STORE) && memMEMWrite;
    case (memFunct3)
      F3_B, F3_H, F3_W: legal = is_load || is_store;
      F3_BU, F3_HU:     legal = is_load;
      default:          legal = 1'b0;
    endcase
    // funct3[1:0]==01 covers both LH/SH and LHU
    misal = legal && (((memFunct3[1:0] == 2'b01) && memResult[0]) ||
                      ((memFunct3 == F3_W) && (memResult[1:0] != 2'b00)));
    go    = legal && !misal;
  end

  // Store lane replication and byte enables; loads always read the full word.
  always_comb begin
    cmd_nxt.we   = is_store;
    cmd_nxt.addr = {memResult[31:2], 2'b00};
    case (memFunct3[1:0])
      2'b00: begin
        cmd_nxt.be    = 4'b0001 << memResult[1:0];
        cmd_nxt.wdata = {4{memMEMWdata[7:0]}};
      end
      2'b01: begin
        cmd_nxt.be    = 4'b0011 << {memResult[1], 1'b0};
        cmd_nxt.wdata = {2{memMEMWdata[15:0]}};
      end
      default: begin
        cmd_nxt.be    = 4'b1111;
        cmd_nxt.wdata = memMEMWdata;
      end
    endcase
    if (!is_store) cmd_nxt.be = 4'b1111;
  end

  // Lane select uses the captured address/funct3 so extraction does not
  // depend on the pipeline register staying frozen.
  lsu_load_align u_align (
    .rdata  (dbus_rdata),
    .addr   (lo_q),
    .funct3 (f3_q),
    .data   (ld_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cmd         <= '0;
      dbus_req    <= 1'b0;
      lo_q        <= 2'b00;
      f3_q        <= 3'b000;
      memLoadData <= 32'h0;
      memLoadDone <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state    <= REQ;
          cmd      <= cmd_nxt;
          dbus_req <= 1'b1;
          lo_q     <= memResult[1:0];
          f3_q     <= memFunct3;
        end
        REQ: if (dbus_ack) begin
          state    <= DONE;
          dbus_req <= 1'b0;
          if (!cmd.we) begin
            memLoadData <= ld_ext;
            memLoadDone <= 1'b1;
          end
        end
        DONE: begin
          // instruction still present here was just served; never restart
          state       <= IDLE;
          memLoadDone <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbus_we    = cmd.we;
  assign dbus_addr  = cmd.addr;
  assign dbus_wdata = cmd.wdata;
  assign dbus_be    = cmd.be;

  // Combinational flags are forced low while reset is held.
  assign memStall    = rst && (((state == IDLE) && go) || (state == REQ));
  assign memMisalign = rst && misal;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memValid = 1'b0;
  logic [6:0]  memInsType = '0;
  logic [2:0]  memFunct3 = '0;
  logic        memMEMWrite = 1'b0;
  logic [31:0] memResult = '0;
  logic [31:0] memMEMWdata = '0;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        memStall, memLoadDone, memMisalign;
  logic [31:0] memLoadData;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .memValid(memValid), .memInsType(memInsType),
    .memFunct3(memFunct3), .memMEMWrite(memMEMWrite), .memResult(memResult),
    .memMEMWdata(memMEMWdata), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .memStall(memStall),
    .memLoadData(memLoadData), .memLoadDone(memLoadDone),
    .memMisalign(memMisalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    memValid    = 1'b1;
    memInsType  = op;
    memFunct3   = f3;
    memMEMWrite = wr;
    memResult   = addr;
    memMEMWdata = wd;
  endtask

  // kind: 0 aligned legal, 1 misaligned, 2 not an access / illegal funct3
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          kind;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewdata;
    logic [31:0] eload;
  } vec_t;

  vec_t vt[$];
  vec_t v;
  logic [31:0] last_load;
  int stall_cnt;

  initial begin
    vt.push_back('{OP_LD, 3'd0, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 0, 32'h100, 4'b1111, 32'h0, 32'hFFFFFF80});
    vt.push_back('{OP_ST, 3'd1, 1'b1, 32'h202, 32'h0000ABCD, 32'h0, 0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0});
    vt.push_back('{OP_ST, 3'd0, 1'b1, 32'h001, 32'h123456A5, 32'h0, 0, 32'h000, 4'b0010, 32'hA5A5A5A5, 32'h0});
    vt.push_back('{OP_ST, 3'd2, 1'b1, 32'h300, 32'hDEADBEEF, 32'h0, 0, 32'h300, 4'b1111, 32'hDEADBEEF, 32'h0});
    vt.push_back('{OP_LD, 3'd1, 1'b0, 32'h102, 32'h0, 32'h80017FFF, 0, 32'h100, 4'b1111, 32'h0, 32'hFFFF8001});
    vt.push_back('{OP_LD, 3'd5, 1'b0, 32'h100, 32'h0, 32'h8001F00D, 0, 32'h100, 4'b1111, 32'h0, 32'h0000F00D});
    vt.push_back('{OP_LD, 3'd4, 1'b0, 32'h101, 32'h0, 32'h00009A00, 0, 32'h100, 4'b1111, 32'h0, 32'h0000009A});
    vt.push_back('{OP_LD, 3'd2, 1'b0, 32'h104, 32'h0, 32'h12345678, 0, 32'h104, 4'b1111, 32'h0, 32'h12345678});
    vt.push_back('{OP_LD, 3'd0, 1'b0, 32'h002, 32'h0, 32'h00550000, 0, 32'h000, 4'b1111, 32'h0, 32'h00000055});
    vt.push_back('{OP_LD, 3'd0, 1'b0, 32'h101, 32'h0, 32'h0000C300, 0, 32'h100, 4'b1111, 32'h0, 32'hFFFFFFC3});
    vt.push_back('{OP_ST, 3'd1, 1'b1, 32'h20E, 32'h00001234, 32'h0, 0, 32'h20C, 4'b1100, 32'h12341234, 32'h0});
    vt.push_back('{OP_LD, 3'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 32'h0});
    vt.push_back('{OP_ST, 3'd1, 1'b1, 32'h203, 32'h0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 32'h0});
    vt.push_back('{OP_LD, 3'd1, 1'b0, 32'h101, 32'h0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 32'h0});
    vt.push_back('{OP_LD, 3'd3, 1'b0, 32'h100, 32'h0, 32'h0, 2, 32'h0, 4'h0, 32'h0, 32'h0});
    vt.push_back('{OP_ST, 3'd4, 1'b1, 32'h100, 32'h0, 32'h0, 2, 32'h0, 4'h0, 32'h0, 32'h0});
    vt.push_back('{OP_ST, 3'd2, 1'b0, 32'h100, 32'h0, 32'h0, 2, 32'h0, 4'h0, 32'h0, 32'h0});

    // Reset state, with an aligned load presented during reset.
    drive(OP_LD, 3'd2, 1'b0, 32'h0, 32'h0);
    #12;
    chk("rst_req", dbus_req, 0);
    chk("rst_we", dbus_we, 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_wdata", dbus_wdata, 0);
    chk("rst_be", dbus_be, 0);
    chk("rst_ldata", memLoadData, 0);
    chk("rst_ldone", memLoadDone, 0);
    chk("rst_stall", memStall, 0);
    chk("rst_misal", memMisalign, 0);
    memValid = 1'b0;
    rst = 1'b1;
    tick;

    // Table-driven single accesses, zero-wait memory.
    last_load = 32'h0;
    foreach (vt[i]) begin
      v = vt[i];
      drive(v.op, v.f3, v.wr, v.addr, v.wdata);
      dbus_ack = 1'b0;
      #1;
      chk($sformatf("v%0d_misal", i), memMisalign, 32'(v.kind == 1));
      chk($sformatf("v%0d_stall0", i), memStall, 32'(v.kind == 0));
      if (v.kind != 0) begin
        tick;
        chk($sformatf("v%0d_noreq", i), dbus_req, 0);
        chk($sformatf("v%0d_nostall", i), memStall, 0);
        memValid = 1'b0;
        tick;
        continue;
      end
      tick;
      chk($sformatf("v%0d_req", i), dbus_req, 1);
      chk($sformatf("v%0d_stall1", i), memStall, 1);
      chk($sformatf("v%0d_addr", i), dbus_addr, v.eaddr);
      chk($sformatf("v%0d_be", i), dbus_be, v.ebe);
      chk($sformatf("v%0d_we", i), dbus_we, 32'(v.op == OP_ST));
      if (v.op == OP_ST) chk($sformatf("v%0d_wdata", i), dbus_wdata, v.ewdata);
      dbus_ack = 1'b1;
      dbus_rdata = v.rdata;
      tick;
      dbus_ack = 1'b0;
      chk($sformatf("v%0d_stall_done", i), memStall, 0);
      chk($sformatf("v%0d_req_done", i), dbus_req, 0);
      chk($sformatf("v%0d_ldone", i), memLoadDone, 32'(v.op == OP_LD));
      if (v.op == OP_LD) last_load = v.eload;
      chk($sformatf("v%0d_ldata", i), memLoadData, last_load);
      memValid = 1'b0;
      tick;
      chk($sformatf("v%0d_ldone_clr", i), memLoadDone, 0);
    end

    // LW with three wait states: four REQ cycles, five stall cycles.
    stall_cnt = 0;
    drive(OP_LD, 3'd2, 1'b0, 32'h44, 32'h0);
    #1;
    if (memStall) stall_cnt++;
    tick;
    for (int w = 0; w < 4; w++) begin
      if (memStall) stall_cnt++;
      chk($sformatf("ws%0d_req", w), dbus_req, 1);
      chk($sformatf("ws%0d_addr", w), dbus_addr, 32'h44);
      chk($sformatf("ws%0d_be", w), dbus_be, 4'b1111);
      chk($sformatf("ws%0d_we", w), dbus_we, 0);
      chk($sformatf("ws%0d_ldone", w), memLoadDone, 0);
      if (w == 3) begin
        dbus_ack = 1'b1;
        dbus_rdata = 32'hCAFEF00D;
      end
      tick;
    end
    dbus_ack = 1'b0;
    if (memStall) stall_cnt++;
    chk("ws_ldone", memLoadDone, 1);
    chk("ws_ldata", memLoadData, 32'hCAFEF00D);
    chk("ws_stall_cycles", stall_cnt, 5);
    memValid = 1'b0;
    tick;

    // Reset in the second REQ cycle abandons the access.
    drive(OP_LD, 3'd2, 1'b0, 32'h80, 32'h0);
    #1;
    tick;
    tick;
    chk("mr_req_before", dbus_req, 1);
    rst = 1'b0;
    #1;
    chk("mr_req", dbus_req, 0);
    chk("mr_stall", memStall, 0);
    chk("mr_ldata", memLoadData, 0);
    tick;
    rst = 1'b1;
    memValid = 1'b0;
    dbus_ack = 1'b1;
    dbus_rdata = 32'h11111111;
    tick;
    chk("mr_spur_ldone", memLoadDone, 0);
    chk("mr_spur_req", dbus_req, 0);
    tick;
    chk("mr_spur_ldone2", memLoadDone, 0);
    chk("mr_spur_stall", memStall, 0);
    dbus_ack = 1'b0;

    // LHU then SB back-to-back.
    drive(OP_LD, 3'd5, 1'b0, 32'h002, 32'h0);
    #1;
    tick;
    dbus_ack = 1'b1;
    dbus_rdata = 32'h80010000;
    tick;
    dbus_ack = 1'b0;
    chk("bb_ldone", memLoadDone, 1);
    chk("bb_ldata", memLoadData, 32'h00008001);
    chk("bb_req_done", dbus_req, 0);
    tick;
    drive(OP_ST, 3'd0, 1'b1, 32'h001, 32'h000000C7);
    #1;
    chk("bb_sb_stall", memStall, 1);
    chk("bb_ldone_clr", memLoadDone, 0);
    tick;
    chk("bb_sb_req", dbus_req, 1);
    chk("bb_sb_be", dbus_be, 4'b0010);
    chk("bb_sb_we", dbus_we, 1);
    chk("bb_sb_wdata", dbus_wdata, 32'hC7C7C7C7);
    dbus_ack = 1'b1;
    tick;
    dbus_ack = 1'b0;
    chk("bb_sb_ldone", memLoadDone, 0);
    chk("bb_sb_ldata", memLoadData, 32'h00008001);
    memValid = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
